sign_mag_converter_pipe: RTL

- Pipelined, parametrised converter between two's-complement and sign-magnitude encodings, selectable per transaction.
- Carry chain is split into CHUNK-bit stages, each registered, so wide operands close timing. Valid/ready streaming handshake on both sides.
- Sits between the calculator's arithmetic unit and the display/formatting path. Also used in reverse to feed sign-magnitude operands back into the ALU.

---
 rtl/sign_mag_converter_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sign_mag_converter_pipe.sv
// sign_mag_converter_pipe
//   Pipelined converter between two's-complement and sign-magnitude encodings,
//   selected per transaction by in_mode. Each pipeline stage resolves CHUNK bits
//   of the magnitude negation carry chain, so wide operands close timing.
//   Optional build macro CONV_SAT_EN: a mode-0 conversion of the most-negative
//   value saturates to {1, 1...1} instead of producing negative zero.
module sign_mag_converter_pipe #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_exc
);
    localparam int STAGES = (N + CHUNK - 1) / CHUNK;
    localparam int MW     = N - 1;

    // Per-stage transaction state. The carry doubles as the running
    // "sign set and all lower magnitude bits zero" flag: a negation carry only
    // survives a bit position whose original bit was zero.
    logic [STAGES-1:0]         vld_p;
    logic [STAGES-1:0]         mode_p;
    logic [STAGES-1:0]         sign_p;
    logic [STAGES-1:0]         carry_p;
    logic [STAGES-1:0][MW-1:0] mag_p;

    logic advance;

    // Result for a negative operand with zero magnitude in mode 0.
    function automatic logic [N-1:0] most_neg_result();
`ifdef CONV_SAT_EN
        return {1'b1, {MW{1'b1}}};
`else
        return {1'b1, {MW{1'b0}}};
`endif
    endfunction

    // Packs {exc, data} from the fully resolved stage state.
    function automatic logic [N:0] finalize(
        input logic          sign,
        input logic          mode,
        input logic          neg_zero,
        input logic [MW-1:0] mag
    );
        if (!neg_zero) begin
            return {1'b0, sign, mag};
        end
        if (mode) begin
            return {1'b1, {N{1'b0}}};
        end
        return {1'b1, most_neg_result()};
    endfunction

    // Stall-all: every stage moves only when the output slot is free.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = ((k + 1) * CHUNK < MW) ? (k + 1) * CHUNK : MW;

        logic          vld_in;
        logic          mode_in;
        logic          sign_in;
        logic          carry_in;
        logic [MW-1:0] mag_in;
        logic [MW-1:0] mag_nx;
        logic          carry_nx;

        if (k == 0) begin : g_src
            // Stage 0 negates only when the sign is set, so carry-in = sign.
            assign vld_in   = in_valid;
            assign mode_in  = in_mode;
            assign sign_in  = in_data[N-1];
            assign carry_in = in_data[N-1];
            assign mag_in   = in_data[MW-1:0];
        end else begin : g_src
            assign vld_in   = vld_p[k-1];
            assign mode_in  = mode_p[k-1];
            assign sign_in  = sign_p[k-1];
            assign carry_in = carry_p[k-1];
            assign mag_in   = mag_p[k-1];
        end

        // Resolve this stage's slice of the conditional (~m + 1) carry chain.
        always_comb begin
            logic b;
            mag_nx   = mag_in;
            carry_nx = carry_in;
            b        = 1'b0;
            for (int i = LO; i < HI; i++) begin
                b         = mag_in[i] ^ sign_in;
                mag_nx[i] = b ^ carry_nx;
                carry_nx  = b & carry_nx;
            end
        end

        // Stage register; reset discards any in-flight transaction.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p[k]   <= 1'b0;
                mode_p[k]  <= 1'b0;
                sign_p[k]  <= 1'b0;
                carry_p[k] <= 1'b0;
                mag_p[k]   <= '0;
            end else if (advance) begin
                vld_p[k]   <= vld_in;
                mode_p[k]  <= mode_in;
                sign_p[k]  <= sign_in;
                carry_p[k] <= carry_nx;
                mag_p[k]   <= mag_nx;
            end
        end
    end

    // ---- output: sign and exception resolved from the last stage ----
    assign out_valid           = vld_p[STAGES-1];
    assign {out_exc, out_data} = finalize(sign_p[STAGES-1], mode_p[STAGES-1],
                                          carry_p[STAGES-1], mag_p[STAGES-1]);

endmodule
